// File: rtl/pixel_fetch_dma.sv
// -----------------------------------------------------------------------------
// pixel_fetch_dma
//
// Fetches a run of bytes from an Avalon-MM slave (one byte per read, lane 0)
// and streams them out on a valid/ready byte port. Reads are issued only while
// the sum of outstanding reads and buffered bytes stays below FIFO_DEPTH, so
// every returned byte always has a free FIFO slot.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   start, base_addr,      transfer request; address and byte count are
//   length                 sampled when start is accepted in IDLE
//   busy, done             busy while fetching/streaming; done pulses once
//   av_*                   Avalon-MM read master (write_n / byteenable_n tied)
//   px_data/valid/ready    byte stream out
// -----------------------------------------------------------------------------
module pixel_fetch_dma #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             av_chipselect,
    output logic             av_read_n,
    output logic             av_write_n,
    output logic [31:0]      av_address,
    output logic [3:0]       av_byteenable_n,
    input  logic             av_waitrequest,
    input  logic [7:0]       av_readdata,
    input  logic             av_readdatavalid,
    output logic [7:0]       px_data,
    output logic             px_valid,
    input  logic             px_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               px_valid_q, px_valid_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic [CNT_W:0]     inflight_s;

    assign accept_s = req_q & ~av_waitrequest;
    // Responses only count while a transfer is live; stragglers that arrive
    // after a reset abort (state back in IDLE) are dropped.
    assign push_s   = av_readdatavalid & ((state_q == ST_ISSUE) | (state_q == ST_DRAIN))
                      & (outst_q != {CNT_W{1'b0}});
    assign pop_s    = px_valid_q & px_ready;

    // Next-state logic: counters, FIFO bookkeeping, FSM and registered outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = accept_s ? (addr_q + 32'd1) : addr_q;
        issue_cnt_d = accept_s ? (issue_cnt_q - LEN_W'(1)) : issue_cnt_q;
        recv_cnt_d  = pop_s ? (recv_cnt_q - LEN_W'(1)) : recv_cnt_q;
        wr_ptr_d    = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({accept_s, push_s})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != {LEN_W{1'b0}}) begin
                        state_d     = ST_ISSUE;
                        addr_d      = base_addr;
                        issue_cnt_d = length;
                        recv_cnt_d  = length;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (recv_cnt_d == {LEN_W{1'b0}}) begin
                    state_d = ST_FINISH;
                end else if (issue_cnt_d == {LEN_W{1'b0}}) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (recv_cnt_d == {LEN_W{1'b0}}) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Credit is judged on post-edge occupancy. A stalled request can only
        // see that sum fall (pushes move a byte from outstanding to the FIFO,
        // pops free a slot), so a held request is never withdrawn.
        inflight_s = {1'b0, outst_d} + {1'b0, fifo_cnt_d};
        req_d      = (state_d == ST_ISSUE) && (issue_cnt_d != {LEN_W{1'b0}})
                     && (inflight_s < DEPTH_C);
        busy_d     = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_FINISH);
        px_valid_d = (fifo_cnt_d != {CNT_W{1'b0}});
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            issue_cnt_q <= {LEN_W{1'b0}};
            recv_cnt_q  <= {LEN_W{1'b0}};
            outst_q     <= {CNT_W{1'b0}};
            fifo_cnt_q  <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            px_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            outst_q     <= outst_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            px_valid_q  <= px_valid_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count is zero.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_q[wr_ptr_q] <= av_readdata;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign av_chipselect   = req_q;
    assign av_read_n       = ~req_q;
    assign av_write_n      = 1'b1;
    assign av_address      = addr_q;
    assign av_byteenable_n = 4'b1110;
    assign px_data         = mem_q[rd_ptr_q];
    assign px_valid        = px_valid_q;

endmodule
